// File: rtl/debug_access_port.sv
// Debug responder: halts the core, performs one register-file or data-memory access per host
// request, then returns a response. All outputs are registered except the gated write strobes.
module debug_access_port #(
    parameter int unsigned MEM_BYTES    = 1024,
    parameter int unsigned MEM_RD_LAT   = 1,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_target,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        halt_req,
    input  logic        halted,
    output logic [4:0]  dbg_reg_addr,
    output logic        dbg_reg_we,
    output logic [31:0] dbg_reg_wdata,
    input  logic [31:0] dbg_reg_rdata,
    output logic [31:0] dbg_mem_addr,
    output logic        dbg_mem_we,
    output logic [31:0] dbg_mem_wdata,
    input  logic [31:0] dbg_mem_rdata
);

    localparam logic [7:0]  TIMEOUT  = 8'(HALT_TIMEOUT);
    localparam logic [7:0]  LAT_LAST = 8'(MEM_RD_LAT - 1);
    localparam logic [31:0] MEM_LAST = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {StIdle, StHalt, StAccess, StMemWait, StResp} state_e;

    state_e      state_q;
    logic        write_q;
    logic        target_q;
    logic [31:0] addr_q;
    logic [7:0]  cnt_q;
    logic        reg_we_q;
    logic        mem_we_q;
    logic        acc_err;
    logic        reg_is_x0;

    always_comb begin
        acc_err   = target_q ? ((addr_q[1:0] != 2'b00) || (addr_q > MEM_LAST))
                             : (addr_q[31:5] != 27'd0);
        reg_is_x0 = (addr_q[4:0] == 5'd0);
    end

    // Strobes are masked by reset so an in-flight access never lands in the reset cycle.
    assign dbg_reg_we = reg_we_q & ~reset;
    assign dbg_mem_we = mem_we_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            target_q      <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            reg_we_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            halt_req      <= 1'b0;
            dbg_reg_addr  <= '0;
            dbg_reg_wdata <= '0;
            dbg_mem_addr  <= '0;
            dbg_mem_wdata <= '0;
        end else begin
            reg_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q       <= req_write;
                        target_q      <= req_target;
                        addr_q        <= req_addr;
                        cnt_q         <= '0;
                        req_ready     <= 1'b0;
                        halt_req      <= 1'b1;
                        dbg_reg_addr  <= req_addr[4:0];
                        dbg_reg_wdata <= req_wdata;
                        dbg_mem_addr  <= req_addr;
                        dbg_mem_wdata <= req_wdata;
                        state_q       <= StHalt;
                    end
                end
                StHalt: begin
                    if (halted) begin
                        // Strobe is registered here so it is high exactly during ACCESS.
                        if (!acc_err && write_q) begin
                            if (target_q) mem_we_q <= 1'b1;
                            else if (!reg_is_x0) reg_we_q <= 1'b1;
                        end
                        state_q <= StAccess;
                    end else if (cnt_q == TIMEOUT) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StAccess: begin
                    if (acc_err) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state_q    <= StResp;
                    end else if (target_q && !write_q) begin
                        cnt_q   <= '0;
                        state_q <= StMemWait;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= (!target_q && !write_q && !reg_is_x0) ? dbg_reg_rdata : '0;
                        state_q    <= StResp;
                    end
                end
                StMemWait: begin
                    if (cnt_q == LAT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= dbg_mem_rdata;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        halt_req   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_access_port.sv
// Bench for debug_access_port: directed vector table, multi-cycle reset/timeout sequences and
// random requests checked against a spec-level shadow model of the register file and memory.
module tb_debug_access_port;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned LAT       = 2;
    localparam int unsigned TMO       = 255;
    localparam int unsigned AW        = $clog2(MEM_BYTES);

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_write, req_target;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_ready, resp_err, halt_req, halted;
    logic [4:0]  dbg_reg_addr;
    logic        dbg_reg_we, dbg_mem_we;
    logic [31:0] dbg_reg_wdata, dbg_reg_rdata, dbg_mem_addr, dbg_mem_wdata, dbg_mem_rdata;

    always #5 clk = ~clk;

    debug_access_port #(.MEM_BYTES(MEM_BYTES), .MEM_RD_LAT(LAT), .HALT_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_target(req_target), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .halt_req(halt_req), .halted(halted),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_we(dbg_reg_we), .dbg_reg_wdata(dbg_reg_wdata),
        .dbg_reg_rdata(dbg_reg_rdata), .dbg_mem_addr(dbg_mem_addr), .dbg_mem_we(dbg_mem_we),
        .dbg_mem_wdata(dbg_mem_wdata), .dbg_mem_rdata(dbg_mem_rdata)
    );

    // Core-side environment: register file, memory with LAT-cycle read pipeline.
    logic        env_init;
    logic [31:0] rf   [32];
    logic [31:0] mem  [MEM_BYTES/4];
    logic [31:0] pipe [LAT];

    assign dbg_reg_rdata = rf[dbg_reg_addr];
    assign dbg_mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'hFFFF0000 : 32'h0;
            for (int i = 0; i < MEM_BYTES/4; i++) mem[i] <= 32'h0;
        end else begin
            if (dbg_reg_we) rf[dbg_reg_addr] <= dbg_reg_wdata;
            if (dbg_mem_we) mem[dbg_mem_addr[AW-1:2]] <= dbg_mem_wdata;
        end
        pipe[0] <= mem[dbg_mem_addr[AW-1:2]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    int cyc = 0;
    int rp = 0, mp = 0, rcyc = 0, mcyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (dbg_reg_we) begin rp = rp + 1; rcyc = cyc; end
        if (dbg_mem_we) begin mp = mp + 1; mcyc = cyc; end
    end

    int nchk = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level shadow model of core state.
    logic [31:0] srf  [32];
    logic [31:0] smem [MEM_BYTES/4];

    task automatic predict(input logic w, input logic t, input logic [31:0] a,
                           input logic [31:0] d, output logic e, output logic [31:0] rd,
                           output int lat, output int erp, output int emp);
        e = t ? ((a % 4 != 0) || (a > MEM_BYTES - 4)) : (a >= 32);
        rd = 0; lat = 3; erp = 0; emp = 0;
        if (!e) begin
            if (t) begin
                if (w) begin smem[a/4] = d; emp = 1; end
                else begin rd = smem[a/4]; lat = 3 + LAT; end
            end else if (w) begin
                if (a != 0) begin srf[a] = d; erp = 1; end
            end else begin
                rd = (a == 0) ? 32'h0 : srf[a];
            end
        end
    endtask

    task automatic run_txn(input string nm, input logic w, input logic t, input logic [31:0] a,
                           input logic [31:0] d, input int rdly, input logic eerr,
                           input logic [31:0] erd, input int elat, input int erp, input int emp);
        int lat, hs, rp0, mp0;
        lat = 0;
        while (!req_ready && lat < 50) begin step(); lat++; end
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        rp0 = rp; mp0 = mp; hs = cyc;
        req_valid = 1'b1; req_write = w; req_target = t; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        chk({nm, " halt_req"}, 32'(halt_req), 32'd1);
        lat = 1;
        while (!resp_valid && lat < 600) begin step(); lat++; end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " err"}, 32'(resp_err), 32'(eerr));
        chk({nm, " rdata"}, resp_rdata, erd);
        for (int k = 0; k < rdly; k++) begin
            step();
            chk({nm, " hold"}, {29'd0, resp_valid, resp_err, halt_req}, {29'd0, 1'b1, eerr, 1'b1});
            chk({nm, " hold rdata"}, resp_rdata, erd);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({nm, " post"}, {29'd0, resp_valid, halt_req, req_ready}, 32'b001);
        chk({nm, " reg strobes"}, 32'(rp - rp0), 32'(erp));
        chk({nm, " mem strobes"}, 32'(mp - mp0), 32'(emp));
        if (erp == 1) chk({nm, " reg strobe cycle"}, 32'(rcyc), 32'(hs + 2));
        if (emp == 1) chk({nm, " mem strobe cycle"}, 32'(mcyc), 32'(hs + 2));
    endtask

    typedef struct {
        string       nm;
        logic        w, t;
        logic [31:0] a, d;
        int          rdly;
        logic        eerr;
        logic [31:0] erd;
        int          elat, erp, emp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string nm, input logic w, input logic t, input logic [31:0] a,
                       input logic [31:0] d, input int rdly, input logic eerr,
                       input logic [31:0] erd, input int elat, input int erp, input int emp);
        vec_t v;
        v.nm = nm; v.w = w; v.t = t; v.a = a; v.d = d; v.rdly = rdly; v.eerr = eerr;
        v.erd = erd; v.elat = elat; v.erp = erp; v.emp = emp;
        tbl.push_back(v);
    endtask

    initial begin
        logic        e, w, t;
        logic [31:0] rd, a, d;
        int          lat, erp, emp, seen;

        add("x5 write",     1, 0, 32'd5,     32'hDEADBEEF, 0, 0, 32'h0,        3, 1, 0);
        add("x5 read",      0, 0, 32'd5,     32'h0,        1, 0, 32'hDEADBEEF, 3, 0, 0);
        add("x0 write",     1, 0, 32'd0,     32'h12345678, 0, 0, 32'h0,        3, 0, 0);
        add("x0 read",      0, 0, 32'd0,     32'h0,        0, 0, 32'h0,        3, 0, 0);
        add("mem wr 0x10",  1, 1, 32'h10,    32'hA5A5A5A5, 0, 0, 32'h0,        3, 0, 1);
        add("mem rd 0x10",  0, 1, 32'h10,    32'h0,        4, 0, 32'hA5A5A5A5, 5, 0, 0);
        add("mem rd 0x2",   0, 1, 32'h2,     32'h0,        0, 1, 32'h0,        3, 0, 0);
        add("mem rd 0x400", 0, 1, 32'h400,   32'h0,        0, 1, 32'h0,        3, 0, 0);
        add("mem wr 0x3fc", 1, 1, 32'h3FC,   32'h0BADF00D, 0, 0, 32'h0,        3, 0, 1);
        add("mem rd 0x3fc", 0, 1, 32'h3FC,   32'h0,        2, 0, 32'h0BADF00D, 5, 0, 0);
        add("mem wr 0x3fd", 1, 1, 32'h3FD,   32'h1,        0, 1, 32'h0,        3, 0, 0);
        add("mem wr 0x400", 1, 1, 32'h400,   32'h2,        0, 1, 32'h0,        3, 0, 0);
        add("reg wr 0x25",  1, 0, 32'h25,    32'h3,        0, 1, 32'h0,        3, 0, 0);

        for (int i = 0; i < 32; i++) srf[i] = 0;
        for (int i = 0; i < MEM_BYTES/4; i++) smem[i] = 0;

        reset = 1'b1; env_init = 1'b1; halted = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_target = 1'b0;
        req_addr = 0; req_wdata = 0; resp_ready = 1'b0;
        repeat (3) step();
        chk("reset flags", {26'd0, req_ready, resp_valid, resp_err, halt_req, dbg_reg_we,
            dbg_mem_we}, 32'b100000);
        chk("reset rdata", resp_rdata, 32'h0);
        chk("reset mem addr", dbg_mem_addr, 32'h0);
        reset = 1'b0; env_init = 1'b0;
        step();

        foreach (tbl[i]) begin
            predict(tbl[i].w, tbl[i].t, tbl[i].a, tbl[i].d, e, rd, lat, erp, emp);
            run_txn(tbl[i].nm, tbl[i].w, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].rdly,
                    tbl[i].eerr, tbl[i].erd, tbl[i].elat, tbl[i].erp, tbl[i].emp);
        end

        // Reset landing on the ACCESS cycle of a register write must suppress the strobe.
        erp = rp;
        req_valid = 1'b1; req_write = 1'b1; req_target = 1'b0; req_addr = 7;
        req_wdata = 32'h77;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst access idle", {29'd0, halt_req, req_ready, resp_valid}, 32'b010);
        chk("rst access strobe", 32'(rp - erp), 32'd0);
        step();
        chk("rst access x7", rf[7], 32'h0);

        // Halt timeout: TMO+1 HALT cycles then an error response.
        halted = 1'b0;
        run_txn("timeout", 1'b0, 1'b0, 32'd1, 32'h0, 1, 1'b1, 32'h0, TMO + 2, 0, 0);

        // Reset while waiting in HALT: request dropped, no response ever.
        req_valid = 1'b1; req_write = 1'b0; req_target = 1'b0; req_addr = 3;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst halt idle", {29'd0, halt_req, req_ready, resp_valid}, 32'b010);
        seen = 0;
        for (int k = 0; k < TMO + 20; k++) begin
            step();
            if (resp_valid || halt_req) seen = 1;
        end
        chk("rst halt no resp", 32'(seen), 32'd0);
        halted = 1'b1;

        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom);
            t = 1'($urandom);
            if (!t) a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
            else if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1100));
            else a = 32'($urandom_range(0, MEM_BYTES/4 - 1)) * 4;
            d = $urandom;
            predict(w, t, a, d, e, rd, lat, erp, emp);
            run_txn($sformatf("rand%0d", n), w, t, a, d, $urandom_range(0, 2), e, rd, lat,
                    erp, emp);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
